// File: rtl/knight_uart_pkg.sv
// Shared types and constants for the Knight-side RemoteComm UART endpoint.
package knight_uart_pkg;

  localparam int BITS_PER_FRAME = 10;  // start + 8 data + stop

  // Response bytes understood by RemoteComm
  localparam logic [7:0] POS_ACK   = 8'hA5;
  localparam logic [7:0] MOVE_DONE = 8'h5A;

  typedef enum logic [0:0] {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_t;
  typedef enum logic [0:0] {TX_IDLE = 1'b0, TX_XMIT = 1'b1} tx_state_t;
  typedef enum logic [0:0] {ASM_HIGH = 1'b0, ASM_LOW = 1'b1} asm_state_t;

endpackage

// File: rtl/knight_cmd_uart_if.sv
// Command / response handshake between the UART endpoint and the command processor.
interface knight_cmd_uart_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  // Command processor side
  modport master (input cmd, cmd_rdy, tx_done, output clr_cmd_rdy, resp, trmt);
  // UART endpoint side
  modport slave  (output cmd, cmd_rdy, tx_done, input clr_cmd_rdy, resp, trmt);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receive engine: two-flop synchronizer, mid-bit sampling, byte_rdy / frm_err pulses.
module uart_rx_core
  import knight_uart_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       byte_rdy,
  output logic       frm_err
);

  localparam int CW = $clog2(BAUD_DIV + 1);

  logic            rx_ff1, rx_ff2, rx_prev;
  rx_state_t       state;
  logic [CW-1:0]   baud_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;

  assign rx_data = shreg;

  // Metastability synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= rx;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  // Frame receiver: half-bit delay to mid-start, then one sample per bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_ff2) begin
            baud_cnt <= CW'(BAUD_DIV / 2);
            bit_cnt  <= '0;
            state    <= RX_RECV;
          end
        end
        RX_RECV: begin
          if (baud_cnt == CW'(1)) begin
            baud_cnt <= CW'(BAUD_DIV);
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd0) begin
              // a high mid-start sample means the falling edge was a glitch
              if (rx_ff2) state <= RX_IDLE;
            end else if (bit_cnt == 4'(BITS_PER_FRAME - 1)) begin
              state <= RX_IDLE;
              if (rx_ff2) byte_rdy <= 1'b1;
              else        frm_err  <= 1'b1;
            end else begin
              shreg <= {rx_ff2, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/knight_cmd_uart.sv
// Knight-side RemoteComm endpoint: two-byte command assembly from RX, response byte out on TX.
module knight_cmd_uart
  import knight_uart_pkg::*;
#(
  parameter int BAUD_DIV  = 2604,
  parameter int TO_CYCLES = 3 * 10 * BAUD_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RX,
  output logic               TX,
  knight_cmd_uart_if.slave   bus
);

  localparam int BCW = $clog2(BAUD_DIV);
  localparam int TCW = $clog2(TO_CYCLES + 1);

  logic [7:0]     rx_data;
  logic           byte_rdy, frm_err;
  asm_state_t     asm_state;
  logic [TCW-1:0] to_cnt;
  logic [15:0]    cmd_reg;
  logic           cmd_rdy_reg;
  logic           hi_done, lo_done;

  tx_state_t      tx_state;
  logic [BCW-1:0] tx_baud_cnt;
  logic [3:0]     tx_bit_cnt;
  logic [8:0]     tx_shift;
  logic           tx_reg, tx_done_reg;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (RX),
    .rx_data  (rx_data),
    .byte_rdy (byte_rdy),
    .frm_err  (frm_err)
  );

  assign hi_done = (asm_state == ASM_HIGH) && byte_rdy;
  assign lo_done = (asm_state == ASM_LOW)  && byte_rdy;

  assign bus.cmd     = cmd_reg;
  assign bus.cmd_rdy = cmd_rdy_reg;
  assign bus.tx_done = tx_done_reg;
  assign TX          = tx_reg;

  // Command assembly: high byte, then low byte within the timeout window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state <= ASM_HIGH;
      to_cnt    <= '0;
      cmd_reg   <= '0;
    end else begin
      case (asm_state)
        ASM_HIGH: begin
          if (byte_rdy) begin
            cmd_reg[15:8] <= rx_data;
            to_cnt        <= '0;
            asm_state     <= ASM_LOW;
          end
        end
        ASM_LOW: begin
          if (byte_rdy) begin
            cmd_reg[7:0] <= rx_data;
            asm_state    <= ASM_HIGH;
          end else if (frm_err || to_cnt == TCW'(TO_CYCLES)) begin
            asm_state <= ASM_HIGH;
          end else begin
            to_cnt <= to_cnt + TCW'(1);
          end
        end
        default: asm_state <= ASM_HIGH;
      endcase
    end
  end

  // cmd_rdy level: a completed command beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cmd_rdy_reg <= 1'b0;
    else if (lo_done)                 cmd_rdy_reg <= 1'b1;
    else if (hi_done || bus.clr_cmd_rdy) cmd_rdy_reg <= 1'b0;
  end

  // Transmitter: start bit driven on the accepting edge, then LSB-first data and stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_baud_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shift    <= '1;
      tx_reg      <= 1'b1;
      tx_done_reg <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.trmt) begin
            tx_shift    <= {1'b1, bus.resp};
            tx_reg      <= 1'b0;
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_done_reg <= 1'b0;
            tx_state    <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_baud_cnt == BCW'(BAUD_DIV - 1)) begin
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= tx_bit_cnt + 4'd1;
            if (tx_bit_cnt == 4'(BITS_PER_FRAME - 1)) begin
              tx_reg      <= 1'b1;
              tx_done_reg <= 1'b1;
              tx_state    <= TX_IDLE;
            end else begin
              tx_reg   <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[8:1]};
            end
          end else begin
            tx_baud_cnt <= tx_baud_cnt + BCW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knight_cmd_uart.sv
// Self-checking bench for knight_cmd_uart: directed cases plus randomized byte streams.
module tb_knight_cmd_uart;
  import knight_uart_pkg::*;

  localparam int BAUD = 16;
  localparam int TO   = 480;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic tx;

  knight_cmd_uart_if bus_if ();

  knight_cmd_uart #(.BAUD_DIV(BAUD), .TO_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx),
    .TX    (tx),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the command path, in terms of whole bytes
  logic [15:0] exp_cmd  = 16'h0000;
  logic        exp_rdy  = 1'b0;
  bit          pending  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame; just before the stop sample cmd_rdy must still hold its old value
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      if (i == 9) begin
        tick(6);
        chk("rdy_before_stop", bus_if.cmd_rdy, exp_rdy);
        tick(BAUD - 6);
      end else begin
        tick(BAUD);
      end
    end
    rx = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic stop);
    if (!stop) begin
      pending = 1'b0;
    end else if (!pending) begin
      exp_cmd[15:8] = b;
      exp_rdy       = 1'b0;
      pending       = 1'b1;
    end else begin
      exp_cmd[7:0] = b;
      exp_rdy      = 1'b1;
      pending      = 1'b0;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop, input int gap);
    send_frame(b, stop);
    model_byte(b, stop);
    tick(3);
    $display("rx byte %h stop=%0b gap=%0d -> cmd=%h rdy=%0b", b, stop, gap, bus_if.cmd, bus_if.cmd_rdy);
    chk("cmd_rdy", bus_if.cmd_rdy, exp_rdy);
    chk("cmd", bus_if.cmd, exp_cmd);
    tick(gap);
    if (gap >= TO) pending = 1'b0;
  endtask

  task automatic clr_pulse();
    bus_if.clr_cmd_rdy = 1'b1;
    tick(1);
    bus_if.clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    $display("clr_cmd_rdy -> rdy=%0b", bus_if.cmd_rdy);
    chk("clr_cmd_rdy", bus_if.cmd_rdy, exp_rdy);
  endtask

  // Transmit r and check each bit period; optionally fire an ignored trmt at clk 40
  task automatic tx_run(input logic [7:0] r, input bit inject);
    logic [9:0] fr;
    fr = {1'b1, r, 1'b0};
    bus_if.resp = r;
    bus_if.trmt = 1'b1;
    tick(1);
    bus_if.trmt = 1'b0;
    chk("tx_start", tx, 1'b0);
    chk("tx_done_clr", bus_if.tx_done, 1'b0);
    for (int k = 1; k <= 160; k++) begin
      if (inject && k == 40) begin
        bus_if.trmt = 1'b1;
        bus_if.resp = ~r;
      end
      if (inject && k == 41) bus_if.trmt = 1'b0;
      tick(1);
      if (k < 160 && (k % 16 == 8 || k == 15 || k == 16))
        chk("tx_bit", tx, fr[k / 16]);
      if (k == 159) chk("tx_done_early", bus_if.tx_done, 1'b0);
    end
    chk("tx_idle", tx, 1'b1);
    chk("tx_done", bus_if.tx_done, 1'b1);
    bus_if.resp = r;
    tick(20);
    chk("tx_done_hold", bus_if.tx_done, 1'b1);
    $display("tx byte %h inject=%0b done=%0b", r, inject, bus_if.tx_done);
  endtask

  initial begin
    bit seen;
    bus_if.clr_cmd_rdy = 1'b0;
    bus_if.trmt        = 1'b0;
    bus_if.resp        = 8'h00;

    // Reset state
    tick(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_cmd", bus_if.cmd, 16'h0000);
    chk("rst_rdy", bus_if.cmd_rdy, 1'b0);
    chk("rst_tx_done", bus_if.tx_done, 1'b0);
    rst_n = 1'b1;
    tick(5);

    // 1: basic command, hold until cleared
    rx_byte(8'h47, 1'b1, 10);
    rx_byte(8'hF1, 1'b1, 0);
    tick(20);
    chk("rdy_hold", bus_if.cmd_rdy, 1'b1);
    clr_pulse();

    // 2: response byte with an ignored trmt mid-frame
    tx_run(POS_ACK, 1'b1);

    // 3: lone byte times out, then a clean pair
    rx_byte(8'h20, 1'b1, 600);
    rx_byte(8'h20, 1'b1, 5);
    rx_byte(8'h00, 1'b1, 5);

    // 4: framing error on the low byte
    clr_pulse();
    rx_byte(8'h47, 1'b1, 5);
    rx_byte(8'h33, 1'b0, 20);
    rx_byte(8'h06, 1'b1, 5);
    rx_byte(8'h00, 1'b1, 5);

    // 5: reset in the middle of an RX frame and a TX frame
    bus_if.resp = MOVE_DONE;
    bus_if.trmt = 1'b1;
    tick(1);
    bus_if.trmt = 1'b0;
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 4; i++) begin
      rx = 1'($urandom_range(0, 1));
      tick(BAUD);
    end
    rx = 1'b1;
    tick(BAUD / 2);
    rst_n = 1'b0;
    #2;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_cmd", bus_if.cmd, 16'h0000);
    chk("midrst_rdy", bus_if.cmd_rdy, 1'b0);
    chk("midrst_tx_done", bus_if.tx_done, 1'b0);
    tick(3);
    rst_n = 1'b1;
    exp_cmd = 16'h0000;
    exp_rdy = 1'b0;
    pending = 1'b0;
    $display("reset mid-frame -> tx=%0b cmd=%h", tx, bus_if.cmd);
    tick(200);
    chk("post_rst_rdy", bus_if.cmd_rdy, 1'b0);
    rx_byte(8'h47, 1'b1, 5);
    rx_byte(8'hF1, 1'b1, 5);

    // 6: clear on the very edge the command completes; set wins
    rx_byte(8'h5B, 1'b1, 5);
    seen = 1'b0;
    bus_if.clr_cmd_rdy = 1'b1;
    fork
      send_frame(8'hF1, 1'b1);
      begin
        for (int i = 0; i < 250 && !seen; i++) begin
          tick(1);
          if (bus_if.cmd_rdy === 1'b1) begin
            bus_if.clr_cmd_rdy = 1'b0;
            seen = 1'b1;
          end
        end
        bus_if.clr_cmd_rdy = 1'b0;
      end
    join
    model_byte(8'hF1, 1'b1);
    chk("set_wins_seen", seen, 1'b1);
    tick(2);
    $display("clr on completion edge -> cmd=%h rdy=%0b", bus_if.cmd, bus_if.cmd_rdy);
    chk("set_wins_rdy", bus_if.cmd_rdy, exp_rdy);
    chk("set_wins_cmd", bus_if.cmd, exp_cmd);

    // Randomized byte stream with occasional framing errors, timeouts and clears
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      logic       stop;
      int         gap;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      gap  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(600, 700)) : int'($urandom_range(0, 40));
      rx_byte(b, stop, gap);
      if (exp_rdy && $urandom_range(0, 2) == 0) clr_pulse();
    end

    // Randomized full-duplex traffic
    for (int n = 0; n < 3; n++) begin
      logic [7:0] r, b;
      r = 8'($urandom);
      b = 8'($urandom);
      fork
        tx_run(r, n[0]);
        rx_byte(b, 1'b1, 10);
      join
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
